adau_spi_arbiter: RTL and testbench

ADAU_SPI_ARBITER -- requirements
Module: adau_spi_arbiter

---
 rtl/adau_spi_arbiter_pkg.sv | 22 ++
 rtl/adau_spi_arbiter_if.sv | 30 +++
 rtl/adau_cmd_fifo.sv | 57 +++++
 rtl/adau_spi_arbiter.sv | 106 ++++++++++
 tb/tb_adau_spi_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adau_spi_arbiter_pkg.sv
// rtl/adau_spi_arbiter_pkg.sv - shared types and defaults for the ADAU SPI command arbiter
package adau_spi_arbiter_pkg;

  localparam int RT_DEPTH_DEF   = 4;
  localparam int GAP_CYCLES_DEF = 4;
  localparam int CMD_W          = 32;
  localparam int LEVEL_W        = 5;
  localparam int GAP_W          = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Where GAP hands control back to once the idle gap has elapsed.
  typedef enum logic {
    ORIG_INIT = 1'b0,
    ORIG_IDLE = 1'b1
  } origin_e;

endpackage

// File: rtl/adau_spi_arbiter_if.sv
// rtl/adau_spi_arbiter_if.sv - init list, runtime command and SPI master handshake bundle
interface adau_spi_arbiter_if;
  import adau_spi_arbiter_pkg::*;

  logic [CMD_W-1:0]   init_command;
  logic               init_valid;
  logic               init_ready;
  logic               init_done;
  logic [CMD_W-1:0]   rt_command;
  logic               rt_valid;
  logic               rt_ready;
  logic [CMD_W-1:0]   spi_command;
  logic               spi_valid;
  logic               spi_ready;
  logic               init_complete;
  logic [LEVEL_W-1:0] rt_level;

  // Arbiter side.
  modport slave (
    input  init_command, init_valid, init_done, rt_command, rt_valid, spi_ready,
    output init_ready, rt_ready, spi_command, spi_valid, init_complete, rt_level
  );

  // Command sources and SPI master side.
  modport master (
    output init_command, init_valid, init_done, rt_command, rt_valid, spi_ready,
    input  init_ready, rt_ready, spi_command, spi_valid, init_complete, rt_level
  );

endinterface

// File: rtl/adau_cmd_fifo.sv
// rtl/adau_cmd_fifo.sv - runtime command FIFO with occupancy level
module adau_cmd_fifo
  import adau_spi_arbiter_pkg::*;
#(
  parameter int DEPTH = RT_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push_i,
  input  logic [CMD_W-1:0]   push_data_i,
  input  logic               pop_i,
  output logic [CMD_W-1:0]   head_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CMD_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [LEVEL_W-1:0] level_q;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (level_q == LEVEL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LEVEL_W'(1);
        2'b01:   level_q <= level_q - LEVEL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: the level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/adau_spi_arbiter.sv
// rtl/adau_spi_arbiter.sv - arbitrates init list and runtime FIFO onto one SPI master
module adau_spi_arbiter
  import adau_spi_arbiter_pkg::*;
#(
  parameter int RT_DEPTH   = RT_DEPTH_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input logic clk,
  input logic reset_n,
  adau_spi_arbiter_if.slave bus
);

  state_e             state_q, state_d;
  origin_e            origin_q, origin_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               complete_q, complete_d;
  logic               spi_valid;
  logic [CMD_W-1:0]   spi_command;
  logic               init_ready;
  logic               fifo_pop;
  logic [CMD_W-1:0]   fifo_head;
  logic [LEVEL_W-1:0] fifo_level;
  logic               fifo_full;
  logic               fifo_empty;

  adau_cmd_fifo #(.DEPTH(RT_DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (bus.rt_valid),
    .push_data_i (bus.rt_command),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.spi_valid     = spi_valid;
  assign bus.spi_command   = spi_command;
  assign bus.init_ready    = init_ready;
  assign bus.rt_ready      = !fifo_full;
  assign bus.rt_level      = fifo_level;
  assign bus.init_complete = complete_q;

  // State, gap counter and init-complete flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      origin_q   <= ORIG_INIT;
      gap_q      <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      origin_q   <= origin_d;
      gap_q      <= gap_d;
      complete_q <= complete_d;
    end
  end

  // Next state and SPI-side outputs; command is forced to zero whenever not valid.
  always_comb begin
    state_d     = state_q;
    origin_d    = origin_q;
    gap_d       = gap_q;
    complete_d  = complete_q;
    spi_valid   = 1'b0;
    spi_command = '0;
    init_ready  = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_INIT: begin
        spi_valid   = bus.init_valid;
        spi_command = bus.init_valid ? bus.init_command : '0;
        init_ready  = bus.spi_ready;
        if (bus.init_valid && bus.spi_ready) begin
          state_d  = ST_GAP;
          origin_d = ORIG_INIT;
          gap_d    = '0;
        end else if (bus.init_done && !bus.init_valid) begin
          state_d    = ST_IDLE;
          complete_d = 1'b1;
        end
      end
      ST_IDLE: begin
        spi_valid   = !fifo_empty;
        spi_command = fifo_empty ? '0 : fifo_head;
        if (!fifo_empty && bus.spi_ready) begin
          fifo_pop = 1'b1;
          state_d  = ST_GAP;
          origin_d = ORIG_IDLE;
          gap_d    = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = (origin_q == ORIG_INIT) ? ST_INIT : ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_adau_spi_arbiter.sv
// tb/tb_adau_spi_arbiter.sv - self-checking bench for adau_spi_arbiter
module tb_adau_spi_arbiter;

  typedef struct {
    logic        rt_valid;
    logic [31:0] cmd;
    logic        spi_ready;
    logic        exp_rdy;
    logic        exp_vld;
    logic [4:0]  exp_lvl;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;
  int   cyc;
  logic [31:0] sb[$];
  int          hs_cyc[$];
  vec_t        vecs[$];

  adau_spi_arbiter_if bus();

  adau_spi_arbiter #(.RT_DEPTH(4), .GAP_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [31:0] c, input logic r,
                     input logic erdy, input logic evld, input logic [4:0] elvl);
    vec_t t;
    t.rt_valid = v; t.cmd = c; t.spi_ready = r;
    t.exp_rdy = erdy; t.exp_vld = evld; t.exp_lvl = elvl;
    vecs.push_back(t);
  endtask

  task automatic add_gap(input logic r, input logic [4:0] lvl);
    for (int i = 0; i < 4; i++) add(1'b0, 32'h0, r, 1'b1, 1'b0, lvl);
  endtask

  task automatic send_init(input logic [31:0] c);
    int n;
    bus.init_command = c;
    bus.init_valid   = 1'b1;
    sb.push_back(c);
    #1;
    n = 0;
    while (!bus.init_ready && n < 20) begin
      tick();
      n++;
    end
    check("init_ready_wait", 32'(n < 20), 32'd1);
    tick();
  endtask

  // Scoreboard: every SPI handshake must match the oldest expected command.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (bus.spi_valid !== 1'b1)
        check("spi_cmd_zero_when_idle", bus.spi_command, 32'h0);
      if (bus.spi_valid === 1'b1 && bus.spi_ready === 1'b1) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_xfer: got 0x%0h want none", bus.spi_command);
        end else begin
          check("spi_xfer", bus.spi_command, sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] init_cmds [3];
    logic [31:0] held;
    n_vec = 0; n_bad = 0; cyc = 0;
    init_cmds[0] = 32'h0040_0001;
    init_cmds[1] = 32'h0040_F9FF;
    init_cmds[2] = 32'h0040_FA03;
    reset_n = 1'b0;
    bus.init_command = '0; bus.init_valid = 1'b0; bus.init_done = 1'b0;
    bus.rt_command = '0; bus.rt_valid = 1'b0; bus.spi_ready = 1'b0;

    // Reset state
    tick();
    check("rst_level", 32'(bus.rt_level), 32'd0);
    check("rst_rt_ready", 32'(bus.rt_ready), 32'd1);
    check("rst_complete", 32'(bus.init_complete), 32'd0);
    check("rst_spi_valid", 32'(bus.spi_valid), 32'd0);
    check("rst_spi_cmd", bus.spi_command, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Init list: three commands, each followed by four idle cycles
    bus.spi_ready = 1'b1;
    hs_cyc.delete();
    for (int i = 0; i < 3; i++) send_init(init_cmds[i]);
    bus.init_valid = 1'b0;
    bus.init_command = '0;
    check("init_xfer_count", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      check("init_spacing_01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd5);
      check("init_spacing_12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd5);
    end
    repeat (5) tick();

    // Runtime push during init is held until init_done
    bus.rt_command = 32'h0040_2300;
    bus.rt_valid = 1'b1;
    #1;
    check("init_push_ready", 32'(bus.rt_ready), 32'd1);
    sb.push_back(32'h0040_2300);
    tick();
    bus.rt_valid = 1'b0;
    #1;
    check("init_push_level", 32'(bus.rt_level), 32'd1);
    check("init_push_no_valid", 32'(bus.spi_valid), 32'd0);
    check("init_push_not_complete", 32'(bus.init_complete), 32'd0);
    bus.spi_ready = 1'b0;
    repeat (3) tick();
    check("init_fifo_not_read", 32'(bus.rt_level), 32'd1);
    bus.init_done = 1'b1;
    #1;
    check("complete_before_edge", 32'(bus.init_complete), 32'd0);
    tick();
    check("complete_set", 32'(bus.init_complete), 32'd1);
    check("idle_valid", 32'(bus.spi_valid), 32'd1);
    check("idle_head", bus.spi_command, 32'h0040_2300);
    held = bus.spi_command;
    repeat (2) tick();
    check("stall_valid", 32'(bus.spi_valid), 32'd1);
    check("stall_cmd_stable", bus.spi_command, held);
    bus.spi_ready = 1'b1;
    tick();
    check("idle_pop_level", 32'(bus.rt_level), 32'd0);
    check("idle_gap_valid", 32'(bus.spi_valid), 32'd0);

    // init_valid after init_complete is ignored
    bus.init_valid = 1'b1;
    bus.init_command = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("late_init_ready", 32'(bus.init_ready), 32'd0);
      check("late_init_valid", 32'(bus.spi_valid), 32'd0);
      tick();
    end
    bus.init_valid = 1'b0;
    bus.init_command = '0;
    check("complete_sticky", 32'(bus.init_complete), 32'd1);

    // FIFO fill, overflow, full push+pop, level-3 push+pop, drain
    add(1, 32'hA000_0001, 0, 1, 0, 1);
    add(1, 32'hA000_0002, 0, 1, 1, 2);
    add(1, 32'hA000_0003, 0, 1, 1, 3);
    add(1, 32'hA000_0004, 0, 1, 1, 4);
    add(1, 32'hA000_0005, 0, 0, 1, 4);
    add(0, 32'h0,         0, 0, 1, 4);
    add(1, 32'hA000_0006, 1, 0, 1, 3);
    add_gap(0, 3);
    add(1, 32'hA000_0007, 1, 1, 1, 3);
    add_gap(1, 3);
    add(0, 32'h0, 1, 1, 1, 2);
    add_gap(1, 2);
    add(0, 32'h0, 1, 1, 1, 1);
    add_gap(1, 1);
    add(0, 32'h0, 1, 1, 1, 0);
    add_gap(1, 0);
    add(0, 32'h0, 1, 1, 0, 0);
    foreach (vecs[i]) begin
      bus.rt_valid   = vecs[i].rt_valid;
      bus.rt_command = vecs[i].cmd;
      bus.spi_ready  = vecs[i].spi_ready;
      #1;
      check($sformatf("v%0d_rt_ready", i), 32'(bus.rt_ready), 32'(vecs[i].exp_rdy));
      check($sformatf("v%0d_spi_valid", i), 32'(bus.spi_valid), 32'(vecs[i].exp_vld));
      if (vecs[i].rt_valid && vecs[i].exp_rdy) sb.push_back(vecs[i].cmd);
      tick();
      check($sformatf("v%0d_level", i), 32'(bus.rt_level), 32'(vecs[i].exp_lvl));
    end
    bus.rt_valid = 1'b0;
    bus.rt_command = '0;
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of GAP with two commands buffered
    bus.spi_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rt_command = 32'hB000_0000 + 32'(i);
      bus.rt_valid = 1'b1;
      if (i == 0) sb.push_back(32'hB000_0000);
      tick();
    end
    bus.rt_valid = 1'b0;
    check("pre_rst_level3", 32'(bus.rt_level), 32'd3);
    bus.spi_ready = 1'b1;
    tick();
    bus.spi_ready = 1'b0;
    #1;
    check("gap_level2", 32'(bus.rt_level), 32'd2);
    reset_n = 1'b0;
    tick();
    check("midgap_rst_level", 32'(bus.rt_level), 32'd0);
    check("midgap_rst_valid", 32'(bus.spi_valid), 32'd0);
    check("midgap_rst_complete", 32'(bus.init_complete), 32'd0);
    check("midgap_rst_rt_ready", 32'(bus.rt_ready), 32'd1);
    bus.spi_ready = 1'b1;
    #1;
    check("midgap_rst_in_init", 32'(bus.init_ready), 32'd1);
    bus.spi_ready = 1'b0;
    sb.delete();
    reset_n = 1'b1;
    repeat (3) tick();
    check("post_rst_level", 32'(bus.rt_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
